miriscv_dmem: RTL and testbench

//   Data memory that sits directly downstream of the core's load/store unit.

---
 rtl/miriscv_dmem_if.sv | 22 ++
 rtl/miriscv_dmem.sv | 123 ++++++++++++
 tb/tb_miriscv_dmem.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/miriscv_dmem_if.sv
// LSU-to-data-memory request/response bundle.
// master = load/store unit side, slave = memory side.
interface miriscv_dmem_if;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ready;
    logic        data_err;

    modport master (
        output data_req, data_we, data_be, data_addr, data_wdata,
        input  data_rdata, data_ready, data_err
    );

    modport slave (
        input  data_req, data_we, data_be, data_addr, data_wdata,
        output data_rdata, data_ready, data_err
    );
endinterface

// File: rtl/miriscv_dmem.sv
// Byte-enabled word data memory with programmable wait states.
// Define MIRISCV_DMEM_ERR_EN to flag out-of-range accesses on data_err.
module miriscv_dmem #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    miriscv_dmem_if.slave bus
);

    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT4  = 4'(WAIT_CYCLES);
    localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   off;
    logic [AW-1:0] widx;
    logic          in_range;
    logic          wr_en;
    logic          unused_bits;

    // Offset from the window base wraps mod 2^32; the byte lane bits are dropped.
    assign off  = addr_q - BASE_ADDR;
    assign widx = off[AW+1:2];

`ifdef MIRISCV_DMEM_ERR_EN
    assign in_range = (off[31:2] < DEPTH30);
`else
    assign in_range = 1'b1;
`endif

    assign unused_bits = ^{off[1:0], off[31:AW+2], DEPTH30};

    // A reset landing on the ACCESS edge must not let the write through.
    assign wr_en = (state == ACCESS) && we_q && in_range && !rst_i;

    // Control FSM: capture request, count wait states, access, respond.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.data_req) begin
                        we_q    <= bus.data_we;
                        be_q    <= bus.data_be;
                        addr_q  <= bus.data_addr;
                        wdata_q <= bus.data_wdata;
                        cnt     <= WAIT4;
                        state   <= (WAIT4 != 4'd0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata <= in_range ? mem[widx] : 32'h0;
                    end
                    ready <= 1'b1;
                    err   <= !in_range;
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Byte-lane merge into the addressed word; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (be_q[n]) begin
                    mem[widx][8*n +: 8] <= wdata_q[8*n +: 8];
                end
            end
        end
    end

    assign bus.data_rdata = rdata;
    assign bus.data_ready = ready;

`ifdef MIRISCV_DMEM_ERR_EN
    assign bus.data_err = err;
`else
    assign bus.data_err = 1'b0;
`endif

endmodule

// File: tb/tb_miriscv_dmem.sv
// Directed bench for miriscv_dmem at default parameters (WAIT_CYCLES=2).
// Expectations for the out-of-range read follow MIRISCV_DMEM_ERR_EN.
module tb_miriscv_dmem;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    miriscv_dmem_if bus ();

    miriscv_dmem #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access from a negedge; report cycles until ready, rdata, err.
    task automatic access(input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rd,
                          output logic er);
        lat = 0;
        rd  = 'x;
        er  = 1'bx;
        bus.data_req   = 1'b1;
        bus.data_we    = we;
        bus.data_be    = be;
        bus.data_addr  = addr;
        bus.data_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.data_ready === 1'b1) begin
                rd = bus.data_rdata;
                er = bus.data_err;
                break;
            end
        end
        bus.data_req = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", {31'h0, bus.data_ready}, 32'h0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;

    initial begin
        bus.data_req   = 1'b0;
        bus.data_we    = 1'b0;
        bus.data_be    = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;

        // Reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_rdata", bus.data_rdata, 32'h0);
            check("rst_ready", {31'h0, bus.data_ready}, 32'h0);
            check("rst_err", {31'h0, bus.data_err}, 32'h0);
        end

        // Full-word write, latency WAIT+2
        access(1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, lat, rd, er);
        check("wr_latency", lat, 4);
        check("wr_err", {31'h0, er}, 32'h0);
        check("wr_keeps_rdata", bus.data_rdata, 32'h0);
        access(1'b0, 4'b0000, 32'h10, 32'h0, lat, rd, er);
        check("rd_latency", lat, 4);
        check("rd_0x10", rd, 32'hDEAD_BEEF);

        // Known word at index 0
        access(1'b1, 4'b1111, 32'h0, 32'h0123_4567, lat, rd, er);

        // Byte and half merge; be=0 writes nothing
        access(1'b1, 4'b1111, 32'h20, 32'h1122_3344, lat, rd, er);
        access(1'b1, 4'b0010, 32'h20, 32'hAAAA_AAAA, lat, rd, er);
        access(1'b0, 4'b0000, 32'h20, 32'h0, lat, rd, er);
        check("merge_byte", rd, 32'h1122_AA44);
        access(1'b1, 4'b1100, 32'h20, 32'h5566_5566, lat, rd, er);
        access(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, lat, rd, er);
        check("be0_latency", lat, 4);
        access(1'b0, 4'b0001, 32'h22, 32'h0, lat, rd, er);
        check("merge_half", rd, 32'h5566_AA44);

        // Back-to-back reads with req held; addr wiggled during WAIT
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_be   = 4'b1111;
        bus.data_addr = 32'h0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check($sformatf("b2b_ready_c%0d", c), {31'h0, bus.data_ready},
                  {31'h0, (c >= 4) && ((c - 4) % 5 == 0)});
            if (c == 2) bus.data_addr = 32'h10;
            if (c == 3) bus.data_addr = 32'h0;
            if (c == 4 || c == 14)
                check("b2b_rdata", bus.data_rdata, 32'h0123_4567);
            if (c == 14) bus.data_req = 1'b0;
        end

        // Reset during WAIT discards the write
        access(1'b1, 4'b1111, 32'h40, 32'h0BAD_C0DE, lat, rd, er);
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_be    = 4'b1111;
        bus.data_addr  = 32'h40;
        bus.data_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.data_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_ready", {31'h0, bus.data_ready}, 32'h0);
        check("rst_mid_rdata", bus.data_rdata, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("rst_mid_no_ready", {31'h0, bus.data_ready}, 32'h0);
        end
        access(1'b0, 4'b1111, 32'h40, 32'h0, lat, rd, er);
        check("rst_mid_kept", rd, 32'h0BAD_C0DE);

        // Out-of-range read
        access(1'b0, 4'b1111, 32'h1000, 32'h0, lat, rd, er);
        check("oor_latency", lat, 4);
`ifdef MIRISCV_DMEM_ERR_EN
        check("oor_err", {31'h0, er}, 32'h1);
        check("oor_rdata", rd, 32'h0);
`else
        check("oor_err", {31'h0, er}, 32'h0);
        check("oor_rdata", rd, 32'h0123_4567);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
